// File: rtl/sample_seq_pkg.sv
// sample_seq_pkg: shared widths, sequencer state encoding and a sizing helper
package sample_seq_pkg;
  localparam int DEF_DATA_W   = 10;
  localparam int SAMPLE_CNT_W = 16;
  typedef enum logic [2:0] {
    IDLE, ADC_START, ADC_WAIT, PROC_START, PROC_WAIT, DAC_START, DAC_WAIT
  } state_e;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/tick_sync.sv
// tick_sync: 2-flop synchroniser plus registered rising-edge detect for slow strobes
module tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic [2:0] sh;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh   <= '0;
      rise <= 1'b0;
    end else begin
      sh   <= {sh[1:0], d};
      rise <= sh[1] & ~sh[2];
    end
endmodule

// File: rtl/sample_sequencer.sv
// sample_sequencer: serial ADC -> processor -> DAC sequence per sample tick,
// keeping the two SPI transfers apart and flagging overruns and stalls.
module sample_sequencer
  import sample_seq_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int DAC_CYCLES     = 40
) (
  input  logic                    sysclk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    enable,
  input  logic                    clr_err,
  output logic                    adc_start,
  input  logic                    adc_valid,
  input  logic [DATA_W-1:0]       adc_data,
  output logic [DATA_W-1:0]       proc_data,
  output logic                    proc_strobe,
  input  logic                    proc_done,
  input  logic [DATA_W-1:0]       proc_result,
  output logic [DATA_W-1:0]       dac_data,
  output logic                    dac_load,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout_err,
  output logic [SAMPLE_CNT_W-1:0] sample_cnt
);
  localparam int CNT_W = $clog2(max2(TIMEOUT_CYCLES, DAC_CYCLES) + 1);
  state_e state, next;
  logic [CNT_W-1:0] cnt;
  logic tick_edge, t_end, d_end, timeout;
  tick_sync u_sync (.clk(sysclk), .rst_n(rst_n), .d(tick), .rise(tick_edge));
  assign busy  = state != IDLE;
  assign t_end = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign d_end = cnt == CNT_W'(DAC_CYCLES - 1);
  // a strobe in the final wait cycle beats the timeout
  assign timeout = t_end && ((state == ADC_WAIT && !adc_valid) || (state == PROC_WAIT && !proc_done));
  always_comb begin
    next = state;
    case (state)
      IDLE:       next = tick_edge && enable ? ADC_START : IDLE;
      ADC_START:  next = ADC_WAIT;
      ADC_WAIT:   next = adc_valid ? PROC_START : t_end ? IDLE : ADC_WAIT;
      PROC_START: next = PROC_WAIT;
      PROC_WAIT:  next = proc_done ? DAC_START : t_end ? IDLE : PROC_WAIT;
      DAC_START:  next = DAC_WAIT;
      DAC_WAIT:   next = d_end ? IDLE : DAC_WAIT;
      default:    next = IDLE;
    endcase
  end
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      adc_start   <= 1'b0;
      proc_strobe <= 1'b0;
      dac_load    <= 1'b0;
      proc_data   <= '0;
      dac_data    <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      sample_cnt  <= '0;
    end else begin
      state       <= next;
      cnt         <= next != state ? '0 : cnt + 1'b1;
      adc_start   <= next == ADC_START;
      proc_strobe <= next == PROC_START;
      dac_load    <= next == DAC_START;
      if (state == ADC_WAIT && adc_valid) proc_data <= adc_data;
      if (state == PROC_WAIT && proc_done) dac_data <= proc_result;
      if (state == DAC_WAIT && d_end) sample_cnt <= sample_cnt + 1'b1;
      overrun     <= (tick_edge && busy) || (overrun && !clr_err);
      timeout_err <= timeout || (timeout_err && !clr_err);
    end
endmodule

// File: tb/tb_sample_sequencer.sv
// tb_sample_sequencer: directed scenarios plus random traffic, checked every
// cycle against a stage/countdown model of the sequencer's behaviour.
module tb_sample_sequencer;
  localparam int DW = 10, TO = 2000, DC = 40;
  localparam int S_IDLE = 0, S_ADC = 1, S_ADCW = 2, S_PROC = 3, S_PROCW = 4, S_DAC = 5, S_DACW = 6;
  logic sysclk = 0, rst_n = 0, tick = 0, enable = 0, clr_err = 0, adc_valid = 0, proc_done = 0;
  logic [DW-1:0] adc_data = '0, proc_result = '0;
  logic adc_start, proc_strobe, dac_load, busy, overrun, timeout_err;
  logic [DW-1:0] proc_data, dac_data;
  logic [15:0] sample_cnt;
  int checks = 0, errors = 0;
  int n_adc = 0, n_proc = 0, n_dac = 0;
  bit preload_req = 0;
  int st = S_IDLE, rem = 0;
  bit h[5];
  logic [DW-1:0] m_proc = '0, m_dac = '0;
  logic [15:0] m_cnt = '0;
  bit m_ovr = 0, m_to = 0;

  always #10 sysclk = ~sysclk;

  sample_sequencer #(.DATA_W(DW), .TIMEOUT_CYCLES(TO), .DAC_CYCLES(DC)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .tick(tick), .enable(enable), .clr_err(clr_err),
    .adc_start(adc_start), .adc_valid(adc_valid), .adc_data(adc_data),
    .proc_data(proc_data), .proc_strobe(proc_strobe), .proc_done(proc_done),
    .proc_result(proc_result), .dac_data(dac_data), .dac_load(dac_load), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err), .sample_cnt(sample_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: the tick is seen 3 samples late, each stage lasts one
  // cycle or a countdown budget, strobes are accepted before the budget expires.
  task step_model;
    bit te, so, sto;
    if (!rst_n) begin
      st = S_IDLE; rem = 0; m_proc = '0; m_dac = '0; m_cnt = '0; m_ovr = 0; m_to = 0;
      foreach (h[i]) h[i] = 0;
    end else begin
      for (int i = 4; i > 0; i--) h[i] = h[i-1];
      h[0] = tick;
      te  = h[3] && !h[4];
      so  = te && st != S_IDLE;
      sto = 0;
      case (st)
        S_IDLE:  if (te && enable) st = S_ADC;
        S_ADC:   begin st = S_ADCW; rem = TO; end
        S_ADCW:  if (adc_valid) begin m_proc = adc_data; st = S_PROC; end
                 else begin rem = rem - 1; if (rem == 0) begin sto = 1; st = S_IDLE; end end
        S_PROC:  begin st = S_PROCW; rem = TO; end
        S_PROCW: if (proc_done) begin m_dac = proc_result; st = S_DAC; end
                 else begin rem = rem - 1; if (rem == 0) begin sto = 1; st = S_IDLE; end end
        S_DAC:   begin st = S_DACW; rem = DC; end
        default: begin rem = rem - 1; if (rem == 0) begin st = S_IDLE; m_cnt = m_cnt + 16'd1; end end
      endcase
      if (preload_req) m_cnt = 16'hFFFF;
      m_ovr = so || (m_ovr && !clr_err);
      m_to  = sto || (m_to && !clr_err);
    end
  endtask

  initial forever begin
    @(posedge sysclk);
    step_model();
  end

  initial forever begin
    @(negedge sysclk);
    if (rst_n) begin
      chk("m_adc_start", adc_start, st == S_ADC);
      chk("m_proc_strobe", proc_strobe, st == S_PROC);
      chk("m_dac_load", dac_load, st == S_DAC);
      chk("m_busy", busy, st != S_IDLE);
      chk("m_proc_data", proc_data, m_proc);
      chk("m_dac_data", dac_data, m_dac);
      chk("m_overrun", overrun, m_ovr);
      chk("m_timeout_err", timeout_err, m_to);
      chk("m_sample_cnt", sample_cnt, m_cnt);
      n_adc  += int'(adc_start);
      n_proc += int'(proc_strobe);
      n_dac  += int'(dac_load);
    end
  end

  task automatic run_seq(input logic [DW-1:0] a, input logic [DW-1:0] p);
    int k = 0;
    @(negedge sysclk) tick = 1;
    do begin @(negedge sysclk); k++; end while (!adc_start && k < 20);
    chk("rs_adc_start", adc_start, 1);
    tick = 0;
    repeat (5) @(negedge sysclk);
    adc_valid = 1; adc_data = a;
    @(negedge sysclk) adc_valid = 0;
    repeat (3) @(negedge sysclk);
    proc_done = 1; proc_result = p;
    @(negedge sysclk) proc_done = 0;
    k = 0;
    do begin @(negedge sysclk); k++; end while (busy && k < 200);
    chk("rs_idle", busy, 0);
  endtask

  initial begin
    int k, na, np, nd, hp;
    repeat (3) @(negedge sysclk);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {adc_start, proc_strobe, dac_load}, 0);
    chk("rst_data", {proc_data, dac_data}, 0);
    chk("rst_flags", {overrun, timeout_err, sample_cnt}, 0);
    rst_n = 1; enable = 1;
    repeat (5) @(negedge sysclk);

    // nominal sequence
    tick = 1; k = 0;
    do begin @(negedge sysclk); k++; end while (!adc_start && k < 20);
    chk("adc_start_lat", k, 4);
    tick = 0;
    repeat (29) @(negedge sysclk);
    adc_valid = 1; adc_data = 10'h2A5;
    @(negedge sysclk);
    chk("nom_proc_data", proc_data, 10'h2A5);
    chk("nom_proc_strobe", proc_strobe, 1);
    adc_valid = 0;
    repeat (4) @(negedge sysclk);
    proc_done = 1; proc_result = 10'h15A;
    @(negedge sysclk);
    chk("nom_dac_data", dac_data, 10'h15A);
    chk("nom_dac_load", dac_load, 1);
    proc_done = 0; k = 0;
    do begin @(negedge sysclk); k++; end while (busy && k < 200);
    chk("nom_dac_wait", k, DC + 1);
    chk("nom_sample_cnt", sample_cnt, 1);
    chk("nom_loads", n_dac, 1);

    // ADC stall
    repeat (5) @(negedge sysclk);
    tick = 1; k = 0;
    do begin @(negedge sysclk); k++; end while (!timeout_err && k < TO + 100);
    tick = 0;
    chk("stall_lat", k, TO + 5);
    chk("stall_busy", busy, 0);
    chk("stall_dac_data", dac_data, 10'h15A);
    chk("stall_cnt", sample_cnt, 1);
    chk("stall_strobes", n_proc, 1);
    chk("stall_loads", n_dac, 1);
    @(negedge sysclk) clr_err = 1;
    @(negedge sysclk) clr_err = 0;
    chk("clr_timeout", timeout_err, 0);

    // clr_err coinciding with the timeout
    repeat (5) @(negedge sysclk);
    tick = 1;
    repeat (10) @(negedge sysclk);
    tick = 0;
    repeat (TO + 4 - 10) @(negedge sysclk);
    clr_err = 1;
    @(negedge sysclk) clr_err = 0;
    chk("set_wins", timeout_err, 1);
    @(negedge sysclk) clr_err = 1;
    @(negedge sysclk) clr_err = 0;
    chk("clr_both", {overrun, timeout_err}, 0);

    // overrun during PROC_WAIT
    repeat (5) @(negedge sysclk);
    na = n_adc; nd = n_dac;
    tick = 1; k = 0;
    do begin @(negedge sysclk); k++; end while (!adc_start && k < 20);
    tick = 0;
    repeat (10) @(negedge sysclk);
    adc_valid = 1; adc_data = 10'h0F3;
    @(negedge sysclk) adc_valid = 0;
    repeat (3) @(negedge sysclk);
    tick = 1;
    repeat (8) @(negedge sysclk);
    chk("ovr_flag", overrun, 1);
    chk("ovr_busy", busy, 1);
    proc_done = 1; proc_result = 10'h3C1;
    @(negedge sysclk) proc_done = 0;
    k = 0;
    do begin @(negedge sysclk); k++; end while (busy && k < 200);
    tick = 0;
    repeat (10) @(negedge sysclk);
    chk("ovr_cnt", sample_cnt, 2);
    chk("ovr_dac_data", dac_data, 10'h3C1);
    chk("ovr_one_start", n_adc - na, 1);
    chk("ovr_one_load", n_dac - nd, 1);
    @(negedge sysclk) clr_err = 1;
    @(negedge sysclk) clr_err = 0;

    // reset during DAC_WAIT
    repeat (5) @(negedge sysclk);
    tick = 1; k = 0;
    do begin @(negedge sysclk); k++; end while (!adc_start && k < 20);
    tick = 0;
    repeat (4) @(negedge sysclk);
    adc_valid = 1; adc_data = 10'h111;
    @(negedge sysclk) adc_valid = 0;
    repeat (2) @(negedge sysclk);
    proc_done = 1; proc_result = 10'h222;
    @(negedge sysclk) proc_done = 0;
    repeat (12) @(negedge sysclk);
    chk("mid_busy", busy, 1);
    #5 rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_pulses", {adc_start, proc_strobe, dac_load}, 0);
    chk("arst_data", {proc_data, dac_data}, 0);
    chk("arst_flags", {overrun, timeout_err, sample_cnt}, 0);
    repeat (3) @(negedge sysclk);
    rst_n = 1;
    np = n_proc; nd = n_dac; na = n_adc;
    repeat (60) @(negedge sysclk);
    chk("arst_quiet", (n_adc - na) + (n_proc - np) + (n_dac - nd), 0);
    run_seq(10'h155, 10'h2AA);
    chk("fresh_cnt", sample_cnt, 1);
    chk("fresh_dac", dac_data, 10'h2AA);

    // sample_cnt wrap
    repeat (5) @(negedge sysclk);
    #5 force dut.sample_cnt = 16'hFFFF;
    preload_req = 1;
    @(negedge sysclk);
    #5 release dut.sample_cnt;
    preload_req = 0;
    chk("preload", sample_cnt, 16'hFFFF);
    run_seq(10'h001, 10'h3FF);
    chk("wrap_cnt", sample_cnt, 0);

    // random traffic
    hp = $urandom_range(15, 150);
    for (int c = 0; c < 20000; c++) begin
      @(negedge sysclk);
      hp--;
      if (hp == 0) begin tick = ~tick; hp = $urandom_range(15, 150); end
      enable      = $urandom_range(0, 15) != 0;
      clr_err     = $urandom_range(0, 63) == 0;
      adc_valid   = $urandom_range(0, 15) == 0;
      proc_done   = $urandom_range(0, 7) == 0;
      adc_data    = DW'($urandom);
      proc_result = DW'($urandom);
    end
    tick = 0; adc_valid = 0; proc_done = 0; clr_err = 0;
    k = 0;
    do begin @(negedge sysclk); k++; end while (busy && k < 2 * TO + 200);
    chk("final_idle", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sample_sequencer.md
# sample_sequencer

Per-sample controller for the audio path. On each rising edge of the 10 kHz sample tick it runs one strictly serial sequence: ADC conversion, processor handoff, DAC load. The ADC and DAC SPI engines drive a shared SCK line (ORed), so their transfers must never overlap; this block guarantees that. It also detects overruns and stalls and reports them as sticky error flags.

## Interface
Parameters:
- DATA_W, 10, sample width (ADC, processor and DAC).
- TIMEOUT_CYCLES, 2000, maximum sysclk cycles spent waiting in ADC_WAIT or PROC_WAIT (40 µs at 50 MHz).
- DAC_CYCLES, 40, fixed sysclk cycles reserved for the DAC SPI transfer after dac_load.

Ports:
- sysclk  in  1  system clock, 50 MHz; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  10 kHz sample clock level; asynchronous to the FSM's view and synchronised internally.
- enable  in  1  when 0, new ticks are ignored.
- clr_err  in  1  synchronous clear of overrun and timeout_err.
- adc_start  out  1  one-cycle start pulse to the ADC SPI engine.
- adc_valid  in  1  conversion-complete strobe.
- adc_data  in  DATA_W  converted sample.
- proc_data  out  DATA_W  registered sample sent to the processor.
- proc_strobe  out  1  one-cycle "new sample" pulse.
- proc_done  in  1  processor result-ready strobe.
- proc_result  in  DATA_W  processed sample.
- dac_data  out  DATA_W  registered sample held for the DAC SPI engine.
- dac_load  out  1  one-cycle load pulse to the DAC SPI engine.
- busy  out  1  high whenever the FSM is not in IDLE.
- overrun  out  1  sticky: a tick arrived while busy.
- timeout_err  out  1  sticky: a wait exceeded TIMEOUT_CYCLES.
- sample_cnt  out  16  count of completed sequences; wraps at 16 bits.

## Operation
- States: IDLE, ADC_START, ADC_WAIT, PROC_START, PROC_WAIT, DAC_START, DAC_WAIT.
- IDLE to ADC_START: on tick_edge with enable=1.
- ADC_START: assert adc_start for 1 cycle, then go to ADC_WAIT.
- ADC_WAIT: on adc_valid, capture adc_data into proc_data, then go to PROC_START.
- PROC_START: assert proc_strobe for 1 cycle, then go to PROC_WAIT.
- PROC_WAIT: on proc_done, capture proc_result into dac_data, then go to DAC_START.
- DAC_START: assert dac_load for 1 cycle, then go to DAC_WAIT.
- DAC_WAIT: count DAC_CYCLES, then go to IDLE and increment sample_cnt.
- Timeout:
  - A wait counter is cleared on entry to ADC_WAIT and to PROC_WAIT.
  - When it reaches TIMEOUT_CYCLES: set timeout_err and go to IDLE.
  - dac_data keeps its last value; sample_cnt does not increment.
- Overrun:
  - A tick_edge while busy=1 sets overrun.
  - That tick is dropped; the current sequence is unaffected.
- Deasserting enable mid-sequence lets the sequence complete normally.
- adc_valid outside ADC_WAIT and proc_done outside PROC_WAIT are ignored.
- A set and a clr_err in the same cycle: the set wins.
- Reset values: FSM in IDLE, all pulses 0, proc_data=0, dac_data=0, busy=0, overrun=0, timeout_err=0, sample_cnt=0.
- Reset asserted mid-sequence returns everything to the reset values immediately. No dac_load is issued.

## Timing
- tick passes through a 2-flop synchroniser plus an edge register.
- tick_edge is high exactly 1 cycle, 3 cycles after tick rises.
- ADC_START is entered the cycle after tick_edge.
- Pulses are registered outputs, 1 cycle wide, high during the named state.
- adc_valid sampled high in cycle N: proc_data updates at N+1, proc_strobe is high at N+1.
- proc_done sampled in cycle M: dac_data updates at M+1, dac_load is high at M+1.
- DAC_WAIT lasts exactly DAC_CYCLES cycles.
- busy falls, and sample_cnt increments, on the same edge that enters IDLE.
- Timeout fires in wait cycle TIMEOUT_CYCLES when no strobe has arrived. A strobe arriving in that same cycle is accepted, not timed out.
- Counter widths: $clog2(max(TIMEOUT_CYCLES, DAC_CYCLES)+1).

## Structure
- Shared package sample_seq_pkg holds:
  - DATA_W default;
  - state enum encoding;
  - SAMPLE_CNT_W = 16.
- One sub-module, tick_sync: 2-flop synchroniser plus rising-edge detector, reset by rst_n. It is reusable for other divided-clock strobes.

## Test plan
- Nominal sequence: enable=1, tick rises; adc_valid with 0x2A5 after 30 cycles; proc_done with 0x15A after 5 cycles.
  - Expect: adc_start 4 cycles after tick; proc_data=0x2A5; dac_data=0x15A; one dac_load; busy low DAC_CYCLES after dac_load; sample_cnt=1.
- ADC stall: no adc_valid.
  - Expect: timeout_err=1 after 2000 wait cycles; no proc_strobe, no dac_load; dac_data unchanged; sample_cnt unchanged.
- Overrun: second tick rises during PROC_WAIT.
  - Expect: overrun=1; the first sequence completes; exactly one adc_start in total.
- clr_err and timeout in the same cycle.
  - Expect: timeout_err=1. A later clr_err alone → both flags 0.
- Reset mid-sequence: rst_n low during DAC_WAIT.
  - Expect: all outputs at reset values asynchronously; no further pulses; the next tick starts a fresh sequence.
- sample_cnt wrap: preload to 0xFFFF via 65535 sequences (or force), run one more sequence.
  - Expect: sample_cnt=0x0000.
